// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU request over valid/ready, decodes ALUOp/funct into the
// 4-bit alu_control code, drives the external combinational alu for one EXEC cycle, captures
// its result/zero flag and returns them with a branch decision over a valid/ready response.
// Optional feature macro: ALU_SEQ_STATS_EN adds the saturating op_count output (width CNT_W).
module alu_op_sequencer #(
  parameter int XLEN = 64
`ifdef ALU_SEQ_STATS_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_alu_op,
  input  logic [2:0]      req_funct3,
  input  logic            req_funct7_30,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            resp_zero,
  output logic            resp_taken,
  output logic            resp_illegal
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0] op_count
`endif
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic accept, exec_done, resp_done;

  logic [3:0] dec_control;
  logic       dec_illegal;
  logic       dec_beq;
  logic       dec_bne;

  logic [XLEN-1:0] alu_a_reg, alu_b_reg;
  logic [3:0]      alu_control_reg;
  logic            illegal_reg, beq_reg, bne_reg;

  logic [XLEN-1:0] resp_result_reg;
  logic            resp_zero_reg, resp_taken_reg, resp_illegal_reg;

  // Request decode: illegal encodings still execute as an add so the EXEC cycle is uniform
  always_comb begin
    dec_control = CTRL_ADD;
    dec_illegal = 1'b0;
    dec_beq     = 1'b0;
    dec_bne     = 1'b0;
    case (req_alu_op)
      2'b00: dec_control = CTRL_ADD;
      2'b01: begin
        case (req_funct3)
          3'b000: begin
            dec_control = CTRL_SUB;
            dec_beq     = 1'b1;
          end
          3'b001: begin
            dec_control = CTRL_SUB;
            dec_bne     = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        case ({req_funct7_30, req_funct3})
          4'b0_000: dec_control = CTRL_ADD;
          4'b1_000: dec_control = CTRL_SUB;
          4'b0_111: dec_control = CTRL_AND;
          4'b0_110: dec_control = CTRL_OR;
          default:  dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs; no overlap between request and response phases
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    exec_done  = 1'b0;
    resp_done  = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        exec_done  = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          resp_done  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand/control latch on accept, result capture at the end of EXEC; both hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a_reg        <= '0;
      alu_b_reg        <= '0;
      alu_control_reg  <= CTRL_AND;
      illegal_reg      <= 1'b0;
      beq_reg          <= 1'b0;
      bne_reg          <= 1'b0;
      resp_result_reg  <= '0;
      resp_zero_reg    <= 1'b0;
      resp_taken_reg   <= 1'b0;
      resp_illegal_reg <= 1'b0;
    end else begin
      if (accept) begin
        alu_a_reg       <= req_a;
        alu_b_reg       <= req_b;
        alu_control_reg <= dec_control;
        illegal_reg     <= dec_illegal;
        beq_reg         <= dec_beq;
        bne_reg         <= dec_bne;
      end
      if (exec_done) begin
        resp_result_reg  <= alu_result;
        resp_zero_reg    <= alu_zero;
        resp_taken_reg   <= (beq_reg & alu_zero) | (bne_reg & ~alu_zero);
        resp_illegal_reg <= illegal_reg;
      end
    end
  end

  assign alu_a        = alu_a_reg;
  assign alu_b        = alu_b_reg;
  assign alu_control  = alu_control_reg;
  assign resp_result  = resp_result_reg;
  assign resp_zero    = resp_zero_reg;
  assign resp_taken   = resp_taken_reg;
  assign resp_illegal = resp_illegal_reg;

`ifdef ALU_SEQ_STATS_EN
  logic [CNT_W-1:0] op_count_reg;

  // Completed-response counter, sticks at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count_reg <= '0;
    end else if (resp_done && (op_count_reg != {CNT_W{1'b1}})) begin
      op_count_reg <= op_count_reg + CNT_W'(1);
    end
  end

  assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: models the external alu, keeps a transaction-level model of the
// expected outputs, and compares the DUT against it on every falling edge.
module tb_alu_op_sequencer;

  localparam int XLEN = 64;
`ifdef ALU_SEQ_STATS_EN
  localparam int CNT_W = 4;
  localparam int CNT_MAX = 15;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      req_alu_op = '0;
  logic [2:0]      req_funct3 = '0;
  logic            req_funct7_30 = 1'b0;
  logic [XLEN-1:0] req_a = '0;
  logic [XLEN-1:0] req_b = '0;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] resp_result;
  logic            resp_zero, resp_taken, resp_illegal;
`ifdef ALU_SEQ_STATS_EN
  logic [CNT_W-1:0] op_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

`ifdef ALU_SEQ_STATS_EN
  alu_op_sequencer #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
`else
  alu_op_sequencer #(.XLEN(XLEN)) dut (
`endif
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_alu_op(req_alu_op), .req_funct3(req_funct3), .req_funct7_30(req_funct7_30),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .resp_taken(resp_taken), .resp_illegal(resp_illegal)
`ifdef ALU_SEQ_STATS_EN
    , .op_count(op_count)
`endif
  );

  // Stand-in for the combinational alu
  always_comb begin
    case (alu_control)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Operation kinds: 0 add, 1 sub, 2 and, 3 or. Branch kinds: 0 none, 1 beq, 2 bne.
  function automatic void classify(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                                   output int kind, output bit ill, output int br);
    kind = 0; ill = 0; br = 0;
    if (aop == 2'b00) kind = 0;
    else if (aop == 2'b01) begin
      if (f3 == 3'd0) begin kind = 1; br = 1; end
      else if (f3 == 3'd1) begin kind = 1; br = 2; end
      else ill = 1;
    end else if (aop == 2'b10) begin
      if (!f7 && f3 == 3'd0) kind = 0;
      else if (f7 && f3 == 3'd0) kind = 1;
      else if (!f7 && f3 == 3'd7) kind = 2;
      else if (!f7 && f3 == 3'd6) kind = 3;
      else ill = 1;
    end else ill = 1;
  endfunction

  bit              m_ok = 0;
  bit              m_exec = 0, m_resp = 0;
  logic [63:0]     m_a = '0, m_b = '0;
  logic [3:0]      m_ctrl = '0;
  logic [63:0]     p_res = '0;
  bit              p_taken = 0, p_ill = 0;
  logic [63:0]     m_res = '0;
  bit              m_zero = 0, m_taken = 0, m_ill = 0;
  int              m_cnt = 0;

  always @(posedge clk) begin
    int kind, br;
    bit ill;
    logic [63:0] r;
    if (rst) begin
      m_ok <= 1; m_exec <= 0; m_resp <= 0;
      m_a <= '0; m_b <= '0; m_ctrl <= '0;
      m_res <= '0; m_zero <= 0; m_taken <= 0; m_ill <= 0;
      m_cnt <= 0;
    end else if (m_resp) begin
      if (resp_ready) begin
        m_resp <= 0;
`ifdef ALU_SEQ_STATS_EN
        if (m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
`else
        m_cnt <= m_cnt + 1;
`endif
      end
    end else if (m_exec) begin
      m_exec <= 0; m_resp <= 1;
      m_res <= p_res; m_zero <= (p_res == 0); m_taken <= p_taken; m_ill <= p_ill;
    end else if (req_valid) begin
      classify(req_alu_op, req_funct3, req_funct7_30, kind, ill, br);
      case (kind)
        1: r = req_a - req_b;
        2: r = req_a & req_b;
        3: r = req_a | req_b;
        default: r = req_a + req_b;
      endcase
      m_exec <= 1;
      m_a <= req_a; m_b <= req_b;
      m_ctrl <= (kind == 1) ? 4'b0110 : (kind == 2) ? 4'b0000 : (kind == 3) ? 4'b0001 : 4'b0010;
      p_res <= r;
      p_ill <= ill;
      p_taken <= (br == 1) ? (r == 0) : (br == 2) ? (r != 0) : 1'b0;
    end
  end

  // Compare process: every falling edge once the model has seen a reset
  always @(negedge clk) begin
    if (m_ok) begin
      check("req_ready", req_ready, !(m_exec || m_resp));
      check("resp_valid", resp_valid, m_resp);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_control", alu_control, m_ctrl);
      check("resp_result", resp_result, m_res);
      check("resp_zero", resp_zero, m_zero);
      check("resp_taken", resp_taken, m_taken);
      check("resp_illegal", resp_illegal, m_ill);
`ifdef ALU_SEQ_STATS_EN
      check("op_count", op_count, m_cnt);
`endif
    end
  end

  // ---------------- driver ----------------
  logic [3:0]  s_ctrl;
  logic [63:0] s_res;
  logic        s_zero, s_taken, s_ill;
  int          s_lat;

  task automatic do_op(input logic [1:0] aop, input logic [2:0] f3, input logic f7,
                       input logic [63:0] a, input logic [63:0] b, input int hold);
    int waited;
    @(negedge clk);
    req_alu_op = aop; req_funct3 = f3; req_funct7_30 = f7; req_a = a; req_b = b;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    s_ctrl = alu_control;
    s_lat = 1;
    while (!resp_valid && s_lat < 10) begin
      @(negedge clk);
      s_lat++;
    end
    check("resp_arrives", resp_valid, 1'b1);
    s_res = resp_result; s_zero = resp_zero; s_taken = resp_taken; s_ill = resp_illegal;
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    $display("TXN aluop=%b f3=%b f7=%b a=%h b=%h ctrl=%b result=%h zero=%0d taken=%0d illegal=%0d lat=%0d",
             aop, f3, f7, a, b, s_ctrl, s_res, s_zero, s_taken, s_ill, s_lat);
  endtask

  logic [1:0]  tab_op [12] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10,
                               2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b10};
  logic [2:0]  tab_f3 [12] = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd6, 3'd0,
                               3'd5, 3'd0, 3'd0, 3'd0, 3'd1, 3'd7};
  logic        tab_f7 [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [63:0] tab_a  [12] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd9, 64'hF0F0, 64'hF000, 64'd10,
                               64'd1, 64'd2, 64'd0, 64'd3, 64'd4, 64'd8};
  logic [63:0] tab_b  [12] = '{64'd2, 64'd6, 64'd9, 64'h0FF0, 64'h000F, 64'd3,
                               64'd1, 64'd3, 64'd0, 64'd4, 64'd1, 64'd1};

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_resp_valid", resp_valid, 1'b0);
    check("reset_alu_control", alu_control, 4'b0000);
    check("reset_resp_result", resp_result, 64'd0);

    // R-type add 5+7
    do_op(2'b10, 3'd0, 1'b0, 64'd5, 64'd7, 0);
    check("add_ctrl", s_ctrl, 4'b0010);
    check("add_result", s_res, 64'd12);
    check("add_zero", s_zero, 1'b0);
    check("add_latency", s_lat, 2);
    check("model_add_result", m_res, 64'd12);

    // Reset while in EXEC drops the op
    @(negedge clk);
    req_alu_op = 2'b10; req_funct3 = 3'd0; req_funct7_30 = 1'b0; req_a = 64'd1; req_b = 64'd1;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("exec_before_rst", req_ready, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_exec_req_ready", req_ready, 1'b1);
    check("rst_exec_resp_valid", resp_valid, 1'b0);
`ifdef ALU_SEQ_STATS_EN
    check("rst_exec_op_count", op_count, 0);
`endif
    repeat (3) begin
      @(negedge clk);
      check("rst_no_resp", resp_valid, 1'b0);
    end

    // beq / bne on equal operands
    do_op(2'b01, 3'd0, 1'b0, 64'h1234, 64'h1234, 0);
    check("beq_ctrl", s_ctrl, 4'b0110);
    check("beq_result", s_res, 64'd0);
    check("beq_zero", s_zero, 1'b1);
    check("beq_taken", s_taken, 1'b1);
    check("model_beq_taken", m_taken, 1'b1);
    do_op(2'b01, 3'd1, 1'b0, 64'h1234, 64'h1234, 0);
    check("bne_taken", s_taken, 1'b0);
    check("bne_zero", s_zero, 1'b1);

    // sub wrap 0-1
    do_op(2'b10, 3'd0, 1'b1, 64'd0, 64'd1, 0);
    check("sub_wrap_result", s_res, 64'hFFFF_FFFF_FFFF_FFFF);
    check("sub_wrap_zero", s_zero, 1'b0);
    check("model_sub_wrap", m_res, 64'hFFFF_FFFF_FFFF_FFFF);

    // illegal encodings
    do_op(2'b11, 3'd0, 1'b0, 64'd3, 64'd4, 0);
    check("ill11_flag", s_ill, 1'b1);
    check("ill11_taken", s_taken, 1'b0);
    check("ill11_ctrl", s_ctrl, 4'b0010);
    check("ill11_idle_after", req_ready, 1'b1);
    do_op(2'b10, 3'd4, 1'b0, 64'd3, 64'd4, 0);
    check("ill100_flag", s_ill, 1'b1);
    check("ill100_taken", s_taken, 1'b0);
    check("ill100_idle_after", req_ready, 1'b1);

    // Stalled response (5 cycles of resp_ready low)
    do_op(2'b10, 3'd6, 1'b0, 64'h00F0, 64'h0F00, 5);
    check("stall_or_result", s_res, 64'h0FF0);
    check("stall_idle_after", req_ready, 1'b1);

    // Directed table; also pushes the counter into saturation when stats are enabled
    for (int i = 0; i < 12; i++) begin
      do_op(tab_op[i], tab_f3[i], tab_f7[i], tab_a[i], tab_b[i], i % 3);
    end
    check("tab_last_illegal", s_ill, 1'b1);
`ifdef ALU_SEQ_STATS_EN
    check("op_count_saturated", op_count, CNT_MAX);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
